// File: rtl/sprite_motion_ctrl_if.sv
// Sprite motion bus: raster counters in, committed sprite state out.
// master = raster/pixel side, slave = sprite_motion_ctrl.
interface sprite_motion_ctrl_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       enable;
  logic [9:0] spr_x;
  logic [9:0] spr_y;
  logic       dir_x;
  logic       dir_y;
  logic       spr_hit;
  logic       frame_tick;

  modport master (
    output hc, vc, enable,
    input  spr_x, spr_y, dir_x, dir_y,
    input  spr_hit, frame_tick
  );

  modport slave (
    input  hc, vc, enable,
    output spr_x, spr_y, dir_x, dir_y,
    output spr_hit, frame_tick
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite mover with blanking-time commit and hit flag.
// Macro SPRITE_BOUNCE_EN: edge bounce; undefined: wrap right/down.
module sprite_motion_ctrl #(
  parameter int HTOTAL    = 800,
  parameter int HACTIVE   = 640,
  parameter int VACTIVE   = 480,
  parameter int SPR_W     = 130,
  parameter int SPR_H     = 42,
  parameter int X0        = 105,
  parameter int Y0        = 203,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  sprite_motion_ctrl_if.slave bus
);

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] XMAX11 = 11'(HACTIVE - SPR_W);
  localparam logic [10:0] YMAX11 = 11'(VACTIVE - SPR_H);
  localparam logic [10:0] W11    = 11'(SPR_W);
  localparam logic [10:0] H11    = 11'(SPR_H);
  localparam logic [9:0]  XMAX10 = 10'(HACTIVE - SPR_W);
  localparam logic [9:0]  YMAX10 = 10'(VACTIVE - SPR_H);
  localparam logic [9:0]  DIVM1  = 10'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, COUNT, STEP_X, STEP_Y, COMMIT
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] nx_q, nx_d, ny_q, ny_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dirx_q, dirx_d, diry_q, diry_d;
  logic       tick_q, tick_d;
  logic       hit_q, hit_d;

  logic        vblank_start;
  logic [10:0] sx, sy, ax, ay, hx, vy;
  logic [9:0]  stp_x, stp_y;
  logic        stp_dx, stp_dy;

  assign vblank_start = (bus.hc == 10'(HTOTAL - 1))
                     && (bus.vc == 10'(VACTIVE - 1));
  assign sx = {1'b0, x_q};
  assign sy = {1'b0, y_q};
  assign ax = sx + STEP11;
  assign ay = sy + STEP11;
  assign hx = {1'b0, bus.hc};
  assign vy = {1'b0, bus.vc};

`ifdef SPRITE_BOUNCE_EN
  // Candidate position: clamp at a limit and reverse that axis.
  always_comb begin
    stp_x  = ax[9:0];
    stp_dx = dirx_q;
    if (!dirx_q) begin
      if (ax >= XMAX11) begin
        stp_x  = XMAX10;
        stp_dx = 1'b1;
      end
    end else if (sx <= STEP11) begin
      stp_x  = '0;
      stp_dx = 1'b0;
    end else begin
      stp_x = 10'(sx - STEP11);
    end
    stp_y  = ay[9:0];
    stp_dy = diry_q;
    if (!diry_q) begin
      if (ay >= YMAX11) begin
        stp_y  = YMAX10;
        stp_dy = 1'b1;
      end
    end else if (sy <= STEP11) begin
      stp_y  = '0;
      stp_dy = 1'b0;
    end else begin
      stp_y = 10'(sy - STEP11);
    end
  end
`else
  // Candidate position: move right/down, wrap to 0 past the limit.
  always_comb begin
    stp_x  = (ax > XMAX11) ? '0 : ax[9:0];
    stp_y  = (ay > YMAX11) ? '0 : ay[9:0];
    stp_dx = 1'b0;
    stp_dy = 1'b0;
  end
`endif

  // Pixel inside committed sprite; right/bottom edges exclusive.
  always_comb begin
    hit_d = (hx < 11'(HACTIVE)) && (vy < 11'(VACTIVE))
         && (hx >= sx) && (hx < sx + W11)
         && (vy >= sy) && (vy < sy + H11);
  end

  // Step scheduler: next state, shadow position, commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    y_d     = y_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vblank_start && bus.enable) state_d = COUNT;
      end
      COUNT: begin
        if (cnt_q == DIVM1) begin
          cnt_d   = '0;
          state_d = STEP_X;
        end else begin
          cnt_d   = cnt_q + 10'd1;
          state_d = IDLE;
        end
      end
      STEP_X: begin
        nx_d    = stp_x;
        dx_d    = stp_dx;
        state_d = STEP_Y;
      end
      STEP_Y: begin
        ny_d    = stp_y;
        dy_d    = stp_dy;
        state_d = COMMIT;
      end
      COMMIT: begin
        x_d     = nx_q;
        y_d     = ny_q;
        dirx_d  = dx_q;
        diry_d  = dy_q;
        tick_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any step in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nx_q    <= 10'(X0);
      ny_q    <= 10'(Y0);
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      x_q     <= 10'(X0);
      y_q     <= 10'(Y0);
      dirx_q  <= 1'b0;
      diry_q  <= 1'b0;
      tick_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
      tick_q  <= tick_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.spr_x      = x_q;
  assign bus.spr_y      = y_q;
  assign bus.dir_x      = dirx_q;
  assign bus.dir_y      = diry_q;
  assign bus.spr_hit    = hit_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl.
// dut0 default, dut1 FRAME_DIV=3, dut2 STEP=4 near the right edge.
module tb_sprite_motion_ctrl;

`ifdef SPRITE_BOUNCE_EN
  localparam int X2 = 506;
`else
  localparam int X2 = 509;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hc = '0;
  logic [9:0] vc = '0;
  logic       en0 = 1'b0;
  logic       en1 = 1'b0;
  logic       en2 = 1'b0;
  longint     cyc = 0;
  int         nchk = 0;
  int         nfail = 0;
  int         k;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sprite_motion_ctrl_if b0 ();
  sprite_motion_ctrl_if b1 ();
  sprite_motion_ctrl_if b2 ();

  assign b0.hc = hc;
  assign b0.vc = vc;
  assign b0.enable = en0;
  assign b1.hc = hc;
  assign b1.vc = vc;
  assign b1.enable = en1;
  assign b2.hc = hc;
  assign b2.vc = vc;
  assign b2.enable = en2;

  sprite_motion_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  sprite_motion_ctrl #(.FRAME_DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  sprite_motion_ctrl #(.STEP(4), .X0(X2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  logic       tk [3];
  logic [9:0] ox [3];
  logic [9:0] oy [3];
  logic       odx [3];
  logic       ody [3];

  assign tk[0]  = b0.frame_tick;
  assign tk[1]  = b1.frame_tick;
  assign tk[2]  = b2.frame_tick;
  assign ox[0]  = b0.spr_x;
  assign ox[1]  = b1.spr_x;
  assign ox[2]  = b2.spr_x;
  assign oy[0]  = b0.spr_y;
  assign oy[1]  = b1.spr_y;
  assign oy[2]  = b2.spr_y;
  assign odx[0] = b0.dir_x;
  assign odx[1] = b1.dir_x;
  assign odx[2] = b2.dir_x;
  assign ody[0] = b0.dir_y;
  assign ody[1] = b1.dir_y;
  assign ody[2] = b2.dir_y;

  typedef struct {
    int     id;
    longint due;
    int     x;
    int     y;
    int     dx;
    int     dy;
  } step_t;

  typedef struct {
    longint due;
    int     exp;
    int     h;
    int     v;
  } hit_t;

  step_t sq[$];
  hit_t  hq[$];

  task automatic chk(string nm, int act, int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected commit lands 4 cycles after the sampling edge.
  task automatic push_step(int id, int x, int y, int dx, int dy);
    step_t s;
    s.id = id;
    s.due = cyc + 5;
    s.x = x;
    s.y = y;
    s.dx = dx;
    s.dy = dy;
    sq.push_back(s);
  endtask

  task automatic probe(int h, int v, int e);
    hit_t t;
    hc = 10'(h);
    vc = 10'(v);
    t.due = cyc + 1;
    t.exp = e;
    t.h = h;
    t.v = v;
    hq.push_back(t);
    tick(1);
  endtask

  task automatic vb_pulse();
    hc = 10'd799;
    vc = 10'd479;
    tick(1);
    hc = 10'd0;
    vc = 10'd480;
  endtask

  task automatic frame();
    vb_pulse();
    tick(8);
  endtask

  // Monitor: pops expectations whenever a DUT presents a result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tk[i]) begin
        k = -1;
        for (int j = 0; j < sq.size(); j++)
          if (k < 0 && sq[j].id == i) k = j;
        if (k < 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_tick dut%0d x=%0d y=%0d",
                   i, ox[i], oy[i]);
        end else begin
          chk($sformatf("tick_cycle dut%0d", i),
              int'(cyc), int'(sq[k].due));
          chk($sformatf("spr_x dut%0d", i), int'(ox[i]), sq[k].x);
          chk($sformatf("spr_y dut%0d", i), int'(oy[i]), sq[k].y);
          chk($sformatf("dir_x dut%0d", i), int'(odx[i]), sq[k].dx);
          chk($sformatf("dir_y dut%0d", i), int'(ody[i]), sq[k].dy);
          sq.delete(k);
        end
      end
    end
    if (hq.size() > 0 && hq[0].due == cyc) begin
      chk($sformatf("spr_hit (%0d,%0d)", hq[0].h, hq[0].v),
          int'(b0.spr_hit), hq[0].exp);
      void'(hq.pop_front());
    end
  end

  initial begin
    // reset held during a live frame, pixel inside sprite
    rst_n = 1'b0;
    hc = 10'd120;
    vc = 10'd210;
    tick(3);
    chk("rst spr_x", int'(b0.spr_x), 105);
    chk("rst spr_y", int'(b0.spr_y), 203);
    chk("rst dir_x", int'(b0.dir_x), 0);
    chk("rst dir_y", int'(b0.dir_y), 0);
    chk("rst spr_hit", int'(b0.spr_hit), 0);
    chk("rst frame_tick", int'(b0.frame_tick), 0);
    rst_n = 1'b1;
    hc = '0;
    vc = '0;
    tick(2);

    // hit window edges
    probe(105, 203, 1);
    probe(234, 244, 1);
    probe(235, 244, 0);
    probe(104, 203, 0);
    probe(170, 245, 0);
    probe(170, 202, 0);
    probe(170, 220, 1);
    hc = '0;
    vc = '0;
    tick(3);

    // single step; enable dropped mid-step must not cancel it
    en0 = 1'b1;
    push_step(0, 106, 204, 0, 0);
    vb_pulse();
    en0 = 1'b0;
    tick(8);
    en0 = 1'b1;
    push_step(0, 107, 205, 0, 0);
    frame();
    en0 = 1'b0;
    frame();

    // reset in the middle of a step aborts it
    en0 = 1'b1;
    vb_pulse();
    tick(1);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    en0 = 1'b0;
    chk("abort spr_x", int'(b0.spr_x), 105);
    chk("abort spr_y", int'(b0.spr_y), 203);
    chk("abort frame_tick", int'(b0.frame_tick), 0);
    tick(8);
    chk("abort hold spr_x", int'(b0.spr_x), 105);

    // frame divider 3, then a 2-frame enable gap
    en1 = 1'b1;
    for (int f = 1; f <= 9; f++) begin
      if (f % 3 == 0) push_step(1, 105 + f / 3, 203 + f / 3, 0, 0);
      frame();
    end
    frame();
    en1 = 1'b0;
    frame();
    frame();
    en1 = 1'b1;
    frame();
    push_step(1, 109, 207, 0, 0);
    frame();
    en1 = 1'b0;
    frame();

    // right-edge behaviour with STEP=4
    en2 = 1'b1;
`ifdef SPRITE_BOUNCE_EN
    push_step(2, 510, 207, 1, 0);
    frame();
    push_step(2, 506, 211, 1, 0);
    frame();
`else
    push_step(2, 0, 207, 0, 0);
    frame();
    push_step(2, 4, 211, 0, 0);
    frame();
`endif
    en2 = 1'b0;
    frame();

    tick(10);
    chk("steps outstanding", sq.size(), 0);
    chk("hits outstanding", hq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
